// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial MSB-first pattern transmitter with repeat,
// inter-frame gaps and a start/busy/done handshake.
module seq_pattern_gen #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [CNT_W-1:0] repeats,
    input  logic [CNT_W-1:0] gap,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [CNT_W-1:0] gap_q;
    logic [LEN_W-1:0] bit_idx;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] gap_cnt;
    logic [LEN_W-1:0] len_eff;
    logic [LEN_W-1:0] len_top;

    // Shift-based bit pick avoids an index wider than the pattern.
    function automatic logic pick(
        input logic [PAT_W-1:0] p,
        input logic [LEN_W-1:0] idx
    );
        logic [PAT_W-1:0] s;
        s = p >> idx;
        return s[0];
    endfunction

    // Clamp the requested length: 0 or oversize means a full pattern.
    always_comb begin
        len_eff = len;
        if (len == '0 || len > LEN_MAX) begin
            len_eff = LEN_MAX;
        end
        len_top = len_eff - LEN_ONE;
    end

    // Transmit FSM; every output is a register written here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pat_q      <= '0;
            len_q      <= '0;
            gap_q      <= '0;
            bit_idx    <= '0;
            frame_cnt  <= '0;
            gap_cnt    <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    dout       <= 1'b0;
                    dout_valid <= 1'b0;
                    busy       <= 1'b0;
                    if (start && !abort) begin
                        pat_q      <= pattern;
                        len_q      <= len_eff;
                        gap_q      <= gap;
                        frame_cnt  <= repeats;
                        bit_idx    <= len_top;
                        dout       <= pick(pattern, len_top);
                        dout_valid <= 1'b1;
                        busy       <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (abort) begin
                        state      <= IDLE;
                        dout       <= 1'b0;
                        dout_valid <= 1'b0;
                        busy       <= 1'b0;
                    end else if (bit_idx != '0) begin
                        bit_idx <= bit_idx - LEN_ONE;
                        dout    <= pick(pat_q, bit_idx - LEN_ONE);
                    end else if (frame_cnt != '0) begin
                        frame_cnt <= frame_cnt - CNT_ONE;
                        if (gap_q != '0) begin
                            state      <= GAP;
                            gap_cnt    <= gap_q - CNT_ONE;
                            dout       <= 1'b0;
                            dout_valid <= 1'b0;
                        end else begin
                            bit_idx <= len_q - LEN_ONE;
                            dout    <= pick(pat_q, len_q - LEN_ONE);
                        end
                    end else begin
                        state      <= IDLE;
                        dout       <= 1'b0;
                        dout_valid <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end
                end
                GAP: begin
                    if (abort) begin
                        state      <= IDLE;
                        dout       <= 1'b0;
                        dout_valid <= 1'b0;
                        busy       <= 1'b0;
                    end else if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - CNT_ONE;
                    end else begin
                        state      <= SEND;
                        bit_idx    <= len_q - LEN_ONE;
                        dout       <= pick(pat_q, len_q - LEN_ONE);
                        dout_valid <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    dout       <= 1'b0;
                    dout_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_pattern_gen.md
# seq_pattern_gen

Serial pattern generator: the transmit-side counterpart of the team's Moore bit-sequence detectors. It latches a programmable bit pattern and drives it MSB-first onto a one-bit serial line, repeated a set number of times with optional idle gaps between frames. It exists to stimulate and loop back detector blocks, such as a "1111" detector, both on-chip and in benches, and it reports progress through a start/busy/done handshake.

## Interface
- PAT_W, 8, maximum pattern length in bits
- LEN_W, 4, width of `len`; must satisfy 2^LEN_W > PAT_W
- CNT_W, 4, width of `repeat` and `gap`
- clk input 1 — single clock, rising edge
- reset input 1 — asynchronous, active-high; clears all state and outputs immediately
- start input 1 — request to transmit; sampled only when idle
- abort input 1 — synchronous cancel of any transfer in progress
- pattern input PAT_W — bits to send; bit len-1 goes first, bit 0 last
- len input LEN_W — bits per frame; 0 or any value > PAT_W means PAT_W
- repeat input CNT_W — extra frames; total frames = repeat+1
- gap input CNT_W — idle cycles between consecutive frames
- dout output 1 — serial data; 0 whenever dout_valid=0
- dout_valid output 1 — high for each cycle carrying a pattern bit
- busy output 1 — transfer in progress
- done output 1 — one-cycle pulse after the final bit of the final frame

## Operation
- States: IDLE, SEND, GAP.
- All outputs are registered.
- Reset value of every output is 0, and the state is IDLE.
- **IDLE**
  - dout=0, dout_valid=0, busy=0.
  - start=1 and abort=0 at an edge:
    - latch pattern, the effective len, repeat and gap into internal registers;
    - load the bit index to len-1 and the frame counter to repeat;
    - on the same edge, drive dout=pattern[len-1], dout_valid=1, busy=1, and go to SEND.
- Inputs are ignored outside IDLE. Changing inputs mid-transfer has no effect.
- **SEND**
  - Each edge advances to the next lower bit.
  - After bit 0 of a frame is presented:
    - if frames remain and gap>0: go to GAP and decrement the frame counter;
    - if frames remain and gap=0: present the next frame's first bit on the next cycle, with no bubble;
    - if no frames remain: go to IDLE, drive busy=0, dout_valid=0, dout=0, and done=1 for exactly one cycle.
- **GAP**
  - dout=0, dout_valid=0, busy=1 for exactly `gap` cycles.
  - Then the first bit of the next frame is presented and the state returns to SEND.
- **Abort**
  - abort=1 at any edge outside IDLE: go to IDLE; dout, dout_valid and busy go to 0.
  - No done pulse is generated.
  - abort in IDLE: no effect. If it coincides with start, abort wins and nothing is latched.
- **Done cycle**
  - The state is already IDLE during the done cycle, so start asserted in that cycle is accepted.
  - This allows back-to-back transfers separated by exactly one idle cycle.
- **Counter rules**
  - The bit index is LEN_W wide. The frame and gap counters are CNT_W wide.
  - Counters decrement and are tested against zero only; no wrap-around is possible.
- **Reset mid-transfer:** outputs clear asynchronously. No done pulse is generated, and a partial frame is not resumed.

## Timing
- Latency: start sampled at edge k → first bit valid in the cycle following edge k.
- Bit rate: one bit per clk cycle.
- Frame length: len_eff cycles.
- Total busy duration: F·L + (F−1)·G cycles, where F = repeat+1, L = len_eff, G = gap.
- done is asserted on the edge after the last bit's cycle. busy falls on that same edge.
- dout and dout_valid change only on clk edges (except on reset) and are glitch-free for downstream detectors.

## Test plan
- Reset: assert reset mid-SEND with pattern=8'hA5 → all outputs 0 immediately; after release, the block is idle and done never pulses.
- Single frame: pattern=8'h0F, len=4, repeat=0, gap=0 → dout = 1,1,1,1 with dout_valid high for 4 cycles starting one cycle after start; done pulses in cycle 5; busy is high for cycles 1–4.
- Repeat with gap: pattern=8'b101, len=3, repeat=2, gap=2 → valid bits 1,0,1 / 2 idle cycles / 1,0,1 / 2 idle / 1,0,1; busy is 13 cycles; done follows.
- Full-length and clamp: pattern=8'hC3, len=0, then len=12 → both cases send 8 bits 1,1,0,0,0,0,1,1.
- Back-to-back and ignore:
  - start held high through a transfer → no restart mid-transfer;
  - a new transfer begins in the done cycle, giving exactly one valid-low cycle between frames;
  - changing pattern mid-transfer does not alter dout.
- Abort: pattern=8'hFF, len=8, repeat=3; abort on the 5th bit → outputs 0 on the next edge, no done; abort+start in IDLE → nothing sent.
